memshare_rqst_sched: RTL and testbench

Round-robin request scheduler for one memory-share group. It accepts request-flag vectors from the access request generator and issues them to the shared memory ports. It issues at most GRANTS_PER_CYCLE requestors per cycle, splitting a vector over several cycles when it holds more set bits than there are ports. It also drives the selector of the share-group skid buffer, so that conflicted (split) vectors take the delayed path and conflict-free vectors take the pass-through path.

---
 rtl/memshare_rqst_sched.sv | 120 ++++++++++++
 tb/tb_memshare_rqst_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/memshare_rqst_sched.sv
// Round-robin request scheduler for one memory-share group: splits request vectors
// into chunks of at most GRANTS_PER_CYCLE grants and steers the share-group skid buffer.
module memshare_rqst_sched #(
  parameter int SHARE_GROUP_SIZE = 5,
  parameter int GRANTS_PER_CYCLE = 2
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        rqst_valid_i,
  input  logic [SHARE_GROUP_SIZE-1:0] rqst_flag_i,
  output logic                        rqst_ready_o,
  input  logic                        grant_ready_i,
  output logic                        grant_valid_o,
  output logic [SHARE_GROUP_SIZE-1:0] grant_o,
  output logic                        grant_last_o,
  output logic                        skid_sel_o,
  output logic                        busy_o,
  output logic [7:0]                  conflict_cnt_o
);

  localparam int N  = SHARE_GROUP_SIZE;
  localparam int G  = GRANTS_PER_CYCLE;
  localparam int PW = ($clog2(N) < 1) ? 1 : $clog2(N);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t         r_state, w_stateNext;
  logic [N-1:0]   r_pending, w_pendingNext, w_chunk;
  logic [PW-1:0]  r_rrPtr, w_rrPtrNext, w_rrAdvance;
  logic           r_skid, w_skidNext;
  logic [7:0]     r_conflictCnt, w_conflictCntNext;
  logic           w_serve, w_last, w_accept, w_overG;

  // Walk the ring from rr_ptr and take the first G pending requestors; the pointer
  // advances to just past the last one taken.
  always_comb begin
    int idx;
    int taken;
    w_chunk     = '0;
    w_rrAdvance = r_rrPtr;
    taken       = 0;
    idx         = int'(r_rrPtr);
    for (int k = 0; k < N; k++) begin
      if (r_pending[idx] && (taken < G)) begin
        w_chunk[idx] = 1'b1;
        taken        = taken + 1;
        w_rrAdvance  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
      idx = (idx == N - 1) ? 0 : idx + 1;
    end
  end

  always_comb begin
    int ones;
    ones = 0;
    for (int k = 0; k < N; k++) begin
      ones = ones + int'(rqst_flag_i[k]);
    end
    w_overG = (ones > G);
  end

  assign w_serve = (r_state == SERVE);
  assign w_last  = ((r_pending & ~w_chunk) == '0);

  // Ready depends combinationally on grant_ready_i so a new vector loads on the
  // same edge that retires the final chunk.
  assign rqst_ready_o = rstn & (~w_serve | (w_last & grant_ready_i));
  assign w_accept     = rqst_valid_i & rqst_ready_o;

  always_comb begin
    w_stateNext       = r_state;
    w_pendingNext     = r_pending;
    w_rrPtrNext       = r_rrPtr;
    w_skidNext        = r_skid;
    w_conflictCntNext = r_conflictCnt;
    if (w_serve && grant_ready_i) begin
      w_pendingNext = r_pending & ~w_chunk;
      w_rrPtrNext   = w_rrAdvance;
      if (w_last) begin
        w_stateNext = IDLE;
      end
    end
    if (w_accept) begin
      if (rqst_flag_i != '0) begin
        w_pendingNext = rqst_flag_i;
        w_stateNext   = SERVE;
        w_skidNext    = w_overG;
        if (w_overG && (r_conflictCnt != 8'hFF)) begin
          w_conflictCntNext = r_conflictCnt + 8'd1;
        end
      end else begin
        w_stateNext = IDLE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_pending     <= '0;
      r_rrPtr       <= '0;
      r_skid        <= 1'b0;
      r_conflictCnt <= 8'd0;
    end else begin
      r_state       <= w_stateNext;
      r_pending     <= w_pendingNext;
      r_rrPtr       <= w_rrPtrNext;
      r_skid        <= w_skidNext;
      r_conflictCnt <= w_conflictCntNext;
    end
  end

  assign grant_valid_o  = w_serve;
  assign grant_o        = w_serve ? w_chunk : '0;
  assign grant_last_o   = w_serve & w_last;
  assign skid_sel_o     = w_serve & r_skid;
  assign busy_o         = w_serve;
  assign conflict_cnt_o = r_conflictCnt;

endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Directed bench for memshare_rqst_sched (N=5, G=2): cycle table plus reset,
// saturation and mid-service reset sequences.
module tb_memshare_rqst_sched;

  logic       sysClk;
  logic       rstn;
  logic       rqstValid;
  logic [4:0] rqstFlag;
  logic       rqstReady;
  logic       grantReady;
  logic       grantValid;
  logic [4:0] grantVec;
  logic       grantLast;
  logic       skidSel;
  logic       busy;
  logic [7:0] conflictCnt;

  int checks = 0;
  int errors = 0;

  memshare_rqst_sched #(
    .SHARE_GROUP_SIZE(5),
    .GRANTS_PER_CYCLE(2)
  ) dut (
    .sys_clk        (sysClk),
    .rstn           (rstn),
    .rqst_valid_i   (rqstValid),
    .rqst_flag_i    (rqstFlag),
    .rqst_ready_o   (rqstReady),
    .grant_ready_i  (grantReady),
    .grant_valid_o  (grantValid),
    .grant_o        (grantVec),
    .grant_last_o   (grantLast),
    .skid_sel_o     (skidSel),
    .busy_o         (busy),
    .conflict_cnt_o (conflictCnt)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  typedef struct {
    logic       valid;
    logic [4:0] flag;
    logic       gr;
    logic       rdy;
    logic       gv;
    logic [4:0] grant;
    logic       last;
    logic       skid;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic valid, logic [4:0] flag, logic gr, logic rdy, logic gv,
                              logic [4:0] grant, logic last, logic skid, logic bsy, logic [7:0] cnt);
    vec_t v;
    v.valid = valid; v.flag = flag; v.gr = gr;
    v.rdy = rdy; v.gv = gv; v.grant = grant; v.last = last;
    v.skid = skid; v.busy = bsy; v.cnt = cnt;
    return v;
  endfunction

  // Packed view ordering: {ready, valid, grant[4:0], last, skid, busy, cnt[7:0]}
  function automatic logic [17:0] packExp(vec_t v);
    return {v.rdy, v.gv, v.grant, v.last, v.skid, v.busy, v.cnt};
  endfunction

  function automatic logic [17:0] getOut();
    return {rqstReady, grantValid, grantVec, grantLast, skidSel, busy, conflictCnt};
  endfunction

  task automatic applyStimulus(input logic valid, input logic [4:0] flag, input logic gr);
    rqstValid  = valid;
    rqstFlag   = flag;
    grantReady = gr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int accepted;
    int cyc;
    int expCnt;

    vecs[0]  = mk(1, 5'b11111, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd0);
    vecs[1]  = mk(0, 5'b00000, 1,  0, 1, 5'b00011, 0, 1, 1, 8'd1);
    vecs[2]  = mk(0, 5'b00000, 1,  0, 1, 5'b01100, 0, 1, 1, 8'd1);
    vecs[3]  = mk(0, 5'b00000, 1,  1, 1, 5'b10000, 1, 1, 1, 8'd1);
    vecs[4]  = mk(1, 5'b00101, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd1);
    vecs[5]  = mk(0, 5'b00000, 1,  1, 1, 5'b00101, 1, 0, 1, 8'd1);
    vecs[6]  = mk(1, 5'b11011, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd1);
    vecs[7]  = mk(1, 5'b00100, 1,  0, 1, 5'b11000, 0, 1, 1, 8'd2);
    vecs[8]  = mk(1, 5'b00100, 1,  1, 1, 5'b00011, 1, 1, 1, 8'd2);
    vecs[9]  = mk(0, 5'b00000, 1,  1, 1, 5'b00100, 1, 0, 1, 8'd2);
    vecs[10] = mk(1, 5'b01111, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd2);
    vecs[11] = mk(0, 5'b00000, 0,  0, 1, 5'b01001, 0, 1, 1, 8'd3);
    vecs[12] = mk(1, 5'b00001, 0,  0, 1, 5'b01001, 0, 1, 1, 8'd3);
    vecs[13] = mk(0, 5'b00000, 1,  0, 1, 5'b01001, 0, 1, 1, 8'd3);
    vecs[14] = mk(0, 5'b00000, 1,  1, 1, 5'b00110, 1, 1, 1, 8'd3);
    vecs[15] = mk(1, 5'b00000, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd3);
    vecs[16] = mk(0, 5'b00000, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd3);
    vecs[17] = mk(1, 5'b00010, 1,  1, 0, 5'b00000, 0, 0, 0, 8'd3);
    vecs[18] = mk(1, 5'b00001, 0,  0, 1, 5'b00010, 1, 0, 1, 8'd3);
    vecs[19] = mk(1, 5'b00001, 1,  1, 1, 5'b00010, 1, 0, 1, 8'd3);
    vecs[20] = mk(0, 5'b00000, 1,  1, 1, 5'b00001, 1, 0, 1, 8'd3);

    // Reset held for three edges while a vector is offered
    rstn = 1'b0;
    applyStimulus(1'b1, 5'b11111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sysClk);
      #1;
      checkOutput("resetOutputs", 32'(getOut()), 32'h0);
    end
    rstn = 1'b1;
    applyStimulus(1'b0, 5'b00000, 1'b1);
    #1;
    checkOutput("releaseReady", 32'(getOut()), 32'h20000);

    for (int i = 0; i < 21; i++) begin
      @(negedge sysClk);
      applyStimulus(vecs[i].valid, vecs[i].flag, vecs[i].gr);
      #1;
      checkOutput($sformatf("row%0d", i), 32'(getOut()), 32'(packExp(vecs[i])));
    end

    // Back-to-back conflicted vectors drive the counter into saturation
    @(negedge sysClk);
    applyStimulus(1'b1, 5'b11100, 1'b1);
    accepted = 0;
    cyc = 0;
    while (accepted < 260 && cyc < 2000) begin
      if (cyc != 0) @(negedge sysClk);
      #1;
      if (rqstReady) begin
        expCnt = 3 + accepted;
        if (expCnt > 255) expCnt = 255;
        checkOutput("satCount", 32'(conflictCnt), 32'(expCnt));
        accepted++;
      end
      cyc++;
    end
    checkOutput("satAccepts", 32'(accepted), 32'd260);
    @(negedge sysClk);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    cyc = 0;
    #1;
    while (busy && cyc < 100) begin
      @(negedge sysClk);
      #1;
      cyc++;
    end
    checkOutput("drainIdle", 32'(busy), 32'd0);
    checkOutput("satFinal", 32'(conflictCnt), 32'd255);

    // Reset in the middle of a split vector
    @(negedge sysClk);
    applyStimulus(1'b1, 5'b11111, 1'b1);
    @(negedge sysClk);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    #1;
    checkOutput("midServe", 32'({grantValid, busy}), 32'h3);
    @(negedge sysClk);
    rstn = 1'b0;
    #1;
    checkOutput("readyInReset", 32'(rqstReady), 32'd0);
    @(negedge sysClk);
    #1;
    checkOutput("midReset", 32'(getOut()), 32'h0);
    rstn = 1'b1;
    applyStimulus(1'b1, 5'b11111, 1'b1);
    #1;
    checkOutput("postReset", 32'(getOut()), 32'h20000);
    @(negedge sysClk);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    #1;
    checkOutput("rrAfterReset", 32'(getOut()), 32'(packExp(mk(0, 5'b0, 1, 0, 1, 5'b00011, 0, 1, 1, 8'd1))));
    repeat (3) @(negedge sysClk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
